// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode values, instruction field positions and the decoded-op record.
package decode_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ADD_OP = 4'd0;
  localparam logic [3:0] SUB_OP = 4'd1;
  localparam logic [3:0] MUL_OP = 4'd2;
  localparam logic [3:0] DIV_OP = 4'd3;
  localparam logic [3:0] AND_OP = 4'd4;
  localparam logic [3:0] OR_OP  = 4'd5;
  localparam logic [3:0] XOR_OP = 4'd6;
  localparam logic [3:0] LW_OP  = 4'd7;
  localparam logic [3:0] SW_OP  = 4'd8;
  localparam logic [3:0] LI_OP  = 4'd9;
  localparam logic [3:0] JMP_OP = 4'd10;
  localparam logic [3:0] BEQ_OP = 4'd11;
  localparam logic [3:0] BGT_OP = 4'd12;
  localparam logic [3:0] BGE_OP = 4'd13;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RD_MSB  = 27;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_MSB = 23;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_MSB = 19;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;
    logic [XLEN-1:0] store_data;
    logic [3:0]      rd;
    logic            wr_en;
  } dec_op_t;

  function automatic logic is_illegal(input logic [3:0] opc);
    return (opc == 4'd14) || (opc == 4'd15);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: two combinational read ports that see same-cycle writeback, one write port.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATAWIDTH = XLEN,
  parameter int unsigned NREGS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [3:0]           i_wr_addr,
  input  logic [DATAWIDTH-1:0] i_wr_data,
  input  logic [3:0]           i_rd_addr_a,
  input  logic [3:0]           i_rd_addr_b,
  output logic [DATAWIDTH-1:0] o_rd_data_a,
  output logic [DATAWIDTH-1:0] o_rd_data_b
);

  logic [DATAWIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (i_wr_addr != 4'd0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data_a = r_mem[i_rd_addr_a];
    o_rd_data_b = r_mem[i_rd_addr_b];
    if (i_wr_en && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
    if (i_wr_en && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
    // R0 stays zero even when a writeback targets it.
    if (i_rd_addr_a == 4'd0) o_rd_data_a = '0;
    if (i_rd_addr_b == 4'd0) o_rd_data_b = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: operand select, busy scoreboard for RAW/WAW stalls, output register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATAWIDTH = XLEN,
  parameter int unsigned NREGS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [DATAWIDTH-1:0] pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [3:0]           opcode_o,
  output logic [DATAWIDTH-1:0] a_o,
  output logic [DATAWIDTH-1:0] b_o,
  output logic [DATAWIDTH-1:0] cmp_a_o,
  output logic [DATAWIDTH-1:0] cmp_b_o,
  output logic [DATAWIDTH-1:0] store_data_o,
  output logic [3:0]           rd_o,
  output logic                 wr_en_o,
  output logic                 illegal_o,
  input  logic                 wb_en_i,
  input  logic [3:0]           wb_addr_i,
  input  logic [DATAWIDTH-1:0] wb_data_i,
  input  logic                 flush_i
);

  logic [3:0]           w_opc, w_rd, w_rs1, w_rs2;
  logic [DATAWIDTH-1:0] w_imm, w_rs1_data, w_rs2_data;
  logic                 w_use_rs1, w_use_rs2, w_illegal, w_hazard, w_accept;
  logic                 w_out_valid_d;
  logic [NREGS-1:0]     w_busy_eff, w_busy_d;
  dec_op_t              w_op;

  logic                 r_out_valid, r_illegal;
  logic [NREGS-1:0]     r_busy;
  dec_op_t              r_op;

  assign w_opc     = instr_i[OPC_MSB:OPC_LSB];
  assign w_rd      = instr_i[RD_MSB:RD_LSB];
  assign w_rs1     = instr_i[RS1_MSB:RS1_LSB];
  assign w_rs2     = instr_i[RS2_MSB:RS2_LSB];
  assign w_imm     = {{(DATAWIDTH-16){instr_i[IMM_MSB]}}, instr_i[IMM_MSB:IMM_LSB]};
  assign w_illegal = is_illegal(w_opc);

  decode_stage_regfile #(
    .DATAWIDTH(DATAWIDTH),
    .NREGS    (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wb_en_i),
    .i_wr_addr  (wb_addr_i),
    .i_wr_data  (wb_data_i),
    .i_rd_addr_a(w_rs1),
    .i_rd_addr_b(w_rs2),
    .o_rd_data_a(w_rs1_data),
    .o_rd_data_b(w_rs2_data)
  );

  always_comb begin
    w_op        = '0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_op.opcode = w_opc;
    w_op.rd     = w_rd;
    unique case (w_opc)
      ADD_OP, SUB_OP, MUL_OP, DIV_OP, AND_OP, OR_OP, XOR_OP: begin
        w_op.a = w_rs1_data; w_op.b = w_rs2_data; w_op.wr_en = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      LW_OP: begin
        w_op.a = w_rs1_data; w_op.b = w_imm; w_op.wr_en = 1'b1;
        w_use_rs1 = 1'b1;
      end
      SW_OP: begin
        w_op.a = w_rs1_data; w_op.b = w_imm; w_op.store_data = w_rs2_data;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      LI_OP: begin
        w_op.b = w_imm; w_op.wr_en = 1'b1;
      end
      // JMP carries the compare operands but does not depend on them.
      JMP_OP: begin
        w_op.a = pc_i; w_op.b = w_imm; w_op.cmp_a = w_rs1_data; w_op.cmp_b = w_rs2_data;
      end
      BEQ_OP, BGT_OP, BGE_OP: begin
        w_op.a = pc_i; w_op.b = w_imm; w_op.cmp_a = w_rs1_data; w_op.cmp_b = w_rs2_data;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_busy_eff = r_busy;
    if (wb_en_i) w_busy_eff[wb_addr_i] = 1'b0;
  end

  assign w_hazard = (w_use_rs1 && w_busy_eff[w_rs1]) || (w_use_rs2 && w_busy_eff[w_rs2]) ||
                    (w_op.wr_en && w_busy_eff[w_rd]);

  assign in_ready_o = !rst && !w_hazard && !flush_i && (!r_out_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  always_comb begin
    w_busy_d = w_busy_eff;
    if (flush_i && r_out_valid && r_op.wr_en) w_busy_d[r_op.rd] = 1'b0;
    // A new claim beats a same-cycle writeback clear on the same register.
    if (w_accept && w_op.wr_en) w_busy_d[w_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    w_out_valid_d = r_out_valid;
    if (r_out_valid && out_ready_i) w_out_valid_d = 1'b0;
    if (w_accept && !w_illegal)     w_out_valid_d = 1'b1;
    if (flush_i)                    w_out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy      <= '0;
      r_op        <= '0;
    end else begin
      r_out_valid <= w_out_valid_d;
      r_illegal   <= w_accept && w_illegal;
      r_busy      <= w_busy_d;
      if (w_accept && !w_illegal) r_op <= w_op;
    end
  end

  assign out_valid_o  = r_out_valid;
  assign illegal_o    = r_illegal;
  assign opcode_o     = r_op.opcode;
  assign a_o          = r_op.a;
  assign b_o          = r_op.b;
  assign cmp_a_o      = r_op.cmp_a;
  assign cmp_b_o      = r_op.cmp_b;
  assign store_data_o = r_op.store_data;
  assign rd_o         = r_op.rd;
  assign wr_en_o      = r_op.wr_en;

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode/operand-fetch stage of the simple CPU, sitting directly upstream of the combinational ALU. It accepts one 32-bit instruction per cycle from fetch over a valid/ready handshake and reads the register file. It selects the ALU operands and opcode and holds them in an output register. A per-register scoreboard stalls read-after-write and write-after-write hazards until writeback arrives.

## Interface
- DATAWIDTH, 32, register/operand width
- NREGS, 16, architectural registers; R0 reads zero and is never written
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  instruction valid from fetch
- in_ready_o  out  1  stage accepts instruction this cycle
- instr_i  in  32  instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16
- pc_i  in  DATAWIDTH  address of instr_i
- out_valid_o  out  1  decoded op valid toward ALU
- out_ready_i  in  1  downstream consumes op
- opcode_o  out  4  ALU opcode
- a_o, b_o  out  DATAWIDTH  ALU operands
- cmp_a_o, cmp_b_o  out  DATAWIDTH  branch compare operands R[rs1], R[rs2]
- store_data_o  out  DATAWIDTH  R[rs2] for SW
- rd_o  out  4  destination register
- wr_en_o  out  1  op writes rd
- illegal_o  out  1  one-cycle pulse when an opcode of 14 or 15 is consumed
- wb_en_i, wb_addr_i[3:0], wb_data_i[DATAWIDTH-1:0]  in  register writeback
- flush_i  in  1  discard held op

## Operation
- imm = sign-extended imm16.
- Operand selection:
  - ADD/SUB/MUL/DIV/AND/OR/XOR: a=R[rs1], b=R[rs2], wr_en=1.
  - LW: a=R[rs1], b=imm, wr_en=1.
  - SW: a=R[rs1], b=imm, store_data=R[rs2], wr_en=0.
  - LI: a=0, b=imm, wr_en=1.
  - JMP/BEQ/BGT/BGE: a=pc_i, b=imm, cmp_a/cmp_b=R[rs1]/R[rs2], wr_en=0.
- Opcodes 14 and 15 are illegal: the instruction is accepted, dropped, and illegal_o pulses; no out_valid.
- Register file reads bypass writeback: reading wb_addr_i while wb_en_i returns wb_data_i. A write to R0 is ignored.
- Scoreboard busy[NREGS]:
  - Set on acceptance of an op with wr_en and rd≠0.
  - Cleared by wb_en_i at wb_addr_i.
- Hazard: a used source, or rd when wr_en, is busy after applying the same-cycle writeback clear. Unused fields are ignored; R0 is never busy.
- in_ready_o = !rst && !hazard && (!out_valid_o || out_ready_i).
- Same-cycle writeback clear and new set on the same register: set wins.
- flush_i: out_valid_o←0 and the busy bit of the held op's rd is cleared if wr_en. It has priority over acceptance in that cycle: in_ready_o=0.

## Timing
- Latency: instruction accepted at edge N → outputs valid after edge N, stable until out_valid&&out_ready_i.
- Full throughput of 1 op/cycle when out_ready_i=1 and no hazard.
- Outputs hold every value while out_valid_o=1 and out_ready_i=0.
- Reset, including mid-operation, immediately drives:
  - All outputs to 0.
  - All busy bits to 0.
  - All registers to 0.
  - illegal_o to 0.
- in_ready_o=0 during reset.
- Writeback at edge N is visible to a read in the same cycle via the bypass, and in the register array after edge N.

## Structure
- Opcode constants come from the shared opcode header.
- The shared package additionally holds:
  - The instruction field bit positions.
  - The decoded-op struct (opcode, a, b, cmp_a, cmp_b, store_data, rd, wr_en).
  - An is_illegal function.
- One sub-module, regfile: NREGS×DATAWIDTH, two combinational read ports with write bypass, one synchronous write port, R0 fixed zero.
- Scoreboard and output register live in decode_stage.

## Test plan
- Seed R1=34, R2=35 via writeback, then ADD rd3,rs1=1,rs2=2 → next cycle out_valid=1, opcode=ADD_OP, a=34, b=35, rd=3, wr_en=1; busy[3]=1.
- LI rd4 imm16=0xFFFB → a=0, b=0xFFFFFFFB; BEQ at pc 0x40, imm=8, rs1=1, rs2=2 → a=0x40, b=8, cmp_a=34, cmp_b=35, wr_en=0.
- RAW stall: ADD rd3 then SUB rs1=3,rs2=1 → in_ready=0 until wb rd3=69. In the writeback cycle, in_ready=1 and the SUB issues with a=69, b=34.
- Backpressure: out_ready=0 for 3 cycles → outputs stable, in_ready=0; raise out_ready → next op accepted that cycle.
- Illegal: opcode 15 → accepted, illegal_o=1 for exactly one cycle, out_valid stays 0, no busy bit set.
- Flush a held ADD rd3 → out_valid=0 next cycle, busy[3]=0. Assert rst mid-stall → all outputs and busy bits are 0 immediately.
